// File: rtl/conv_sequencer.sv
// ----------------------------------------------------------------------------
// conv_sequencer
//   Row sequencer for a row-at-a-time convolution datapath. A frame either
//   loads M_LEN kernel rows first or reuses the kernel already held in the
//   datapath. It then streams IMG_ROWS image rows. The first M_LEN image rows
//   prime the sliding window. After that, every image row produces one
//   registered result, which is held until the consumer accepts it. At most
//   one image row is in flight at any time.
//
// Ports
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_start, i_keep_kernel  frame request (IDLE only); 1 = reuse stored kernel
//   i_row_valid/o_row_ready upstream row handshake, i_row_data pixel 0 in LSBs
//   o_conv_valid            one datapath issue per row handshake
//   o_conv_selecK_I         0 = kernel row, 1 = image row
//   o_conv_data0..2         row pixels 0..2 to the datapath
//   i_conv_result           datapath sum, sampled two cycles after issue
//   o_result/_valid/_last   held result, valid, last-of-frame flag
//   i_result_ready          result consumer ready
//   o_busy, o_done          not-IDLE flag, one-cycle end-of-frame pulse
// ----------------------------------------------------------------------------
module conv_sequencer #(
  parameter int BIT_LEN  = 8,
  parameter int M_LEN    = 3,
  parameter int CONV_LEN = 20,
  parameter int IMG_ROWS = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_keep_kernel,
  input  logic                       i_row_valid,
  output logic                       o_row_ready,
  input  logic [BIT_LEN*M_LEN-1:0]   i_row_data,
  output logic                       o_conv_valid,
  output logic                       o_conv_selecK_I,
  output logic [BIT_LEN-1:0]         o_conv_data0,
  output logic [BIT_LEN-1:0]         o_conv_data1,
  output logic [BIT_LEN-1:0]         o_conv_data2,
  input  logic [CONV_LEN-1:0]        i_conv_result,
  output logic [CONV_LEN-1:0]        o_result,
  output logic                       o_result_valid,
  input  logic                       i_result_ready,
  output logic                       o_result_last,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_K = 3'd1;
  localparam logic [2:0] LOAD_I = 3'd2;
  localparam logic [2:0] WAIT1  = 3'd3;
  localparam logic [2:0] WAIT2  = 3'd4;
  localparam logic [2:0] OUT    = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // Counters can reach their full limit (M_LEN, IMG_ROWS) without wrapping.
  localparam int K_CNT_W   = $clog2(M_LEN + 1);
  localparam int IMG_CNT_W = $clog2(IMG_ROWS + 1);

  logic [2:0]            state_reg, state_next;
  logic [K_CNT_W-1:0]    k_cnt_reg, k_cnt_next;
  logic [IMG_CNT_W-1:0]  img_cnt_reg, img_cnt_next;
  logic [CONV_LEN-1:0]   result_reg, result_next;
  logic                  row_hs;
  logic [BIT_LEN-1:0]    pix [3];

  // Split the row into datapath pixels. Lanes beyond M_LEN are tied to zero.
  for (genvar gi = 0; gi < 3; gi++) begin : g_pix
    if (gi < M_LEN) begin : g_used
      assign pix[gi] = i_row_data[gi*BIT_LEN +: BIT_LEN];
    end else begin : g_unused
      assign pix[gi] = '0;
    end
  end

  assign o_row_ready     = (state_reg == LOAD_K) || (state_reg == LOAD_I);
  assign row_hs          = i_row_valid & o_row_ready;
  assign o_conv_valid    = row_hs;
  assign o_conv_selecK_I = (state_reg == LOAD_I);
  assign o_conv_data0    = pix[0];
  assign o_conv_data1    = pix[1];
  assign o_conv_data2    = pix[2];

  assign o_result        = result_reg;
  assign o_result_valid  = (state_reg == OUT);
  // The image count stays fixed while in OUT, so the last flag is stable
  // for as long as the result is held.
  assign o_result_last   = (state_reg == OUT) &&
                           (img_cnt_reg == IMG_CNT_W'(IMG_ROWS));
  assign o_busy          = (state_reg != IDLE);
  assign o_done          = (state_reg == DONE);

  always_comb begin
    state_next   = state_reg;
    k_cnt_next   = k_cnt_reg;
    img_cnt_next = img_cnt_reg;
    result_next  = result_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          k_cnt_next   = '0;
          img_cnt_next = '0;
          state_next   = i_keep_kernel ? LOAD_I : LOAD_K;
        end
      end
      LOAD_K: begin
        if (row_hs) begin
          k_cnt_next = k_cnt_reg + 1'b1;
          if (k_cnt_reg == K_CNT_W'(M_LEN - 1)) begin
            state_next = LOAD_I;
          end
        end
      end
      LOAD_I: begin
        if (row_hs) begin
          img_cnt_next = img_cnt_reg + 1'b1;
          // Once the window is primed, every image row yields a result.
          if (img_cnt_reg >= IMG_CNT_W'(M_LEN - 1)) begin
            state_next = WAIT1;
          end
        end
      end
      WAIT1: state_next = WAIT2;
      WAIT2: begin
        result_next = i_conv_result;
        state_next  = OUT;
      end
      OUT: begin
        if (i_result_ready) begin
          state_next = (img_cnt_reg == IMG_CNT_W'(IMG_ROWS)) ? DONE : LOAD_I;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      k_cnt_reg   <= '0;
      img_cnt_reg <= '0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      k_cnt_reg   <= k_cnt_next;
      img_cnt_reg <= img_cnt_next;
      result_reg  <= result_next;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_conv_sequencer
//   Directed frames against conv_sequencer. The bench holds a simple
//   convolution datapath that has two cycles of latency and keeps its kernel
//   across frames. It also holds a frame-level model that computes each
//   expected result as the window dot product of kernel rows and image rows.
// ----------------------------------------------------------------------------
module tb_conv_sequencer;
  localparam int BIT_LEN = 8, M_LEN = 3, CONV_LEN = 20, IMG_ROWS = 8;
  localparam int NRES = IMG_ROWS - M_LEN + 1;

  logic clk = 1'b0;
  logic i_reset, i_start, i_keep_kernel, i_row_valid, i_result_ready;
  logic [BIT_LEN*M_LEN-1:0] i_row_data;
  logic [CONV_LEN-1:0] i_conv_result, o_result;
  logic o_row_ready, o_conv_valid, o_conv_selecK_I;
  logic [BIT_LEN-1:0] o_conv_data0, o_conv_data1, o_conv_data2;
  logic o_result_valid, o_result_last, o_busy, o_done;

  always #5 clk = ~clk;

  conv_sequencer #(.BIT_LEN(BIT_LEN), .M_LEN(M_LEN), .CONV_LEN(CONV_LEN),
                   .IMG_ROWS(IMG_ROWS)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_keep_kernel(i_keep_kernel), .i_row_valid(i_row_valid),
    .o_row_ready(o_row_ready), .i_row_data(i_row_data),
    .o_conv_valid(o_conv_valid), .o_conv_selecK_I(o_conv_selecK_I),
    .o_conv_data0(o_conv_data0), .o_conv_data1(o_conv_data1),
    .o_conv_data2(o_conv_data2), .i_conv_result(i_conv_result),
    .o_result(o_result), .o_result_valid(o_result_valid),
    .i_result_ready(i_result_ready), .o_result_last(o_result_last),
    .o_busy(o_busy), .o_done(o_done));

  int tests = 0, fails = 0;
  int cyc = 0;
  int done_cnt = 0, res_total = 0, k_hs_total = 0;
  int stall_cnt = 0;
  bit gaps = 0;
  int kern_m [3][3];
  int img_m [IMG_ROWS][3];
  int exp_val [$];
  bit exp_last [$];
  int got_q [$];

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- behavioural datapath ----------------
  int dp_k [3][3];
  int dp_w [3][3];
  int dp_ki;
  int dp_s1, dp_s2;

  function automatic int dp_sum(input int n0, input int n1, input int n2);
    int s = 0;
    for (int p = 0; p < 3; p++) begin
      s += dp_k[0][p] * dp_w[1][p] + dp_k[1][p] * dp_w[2][p];
    end
    s += dp_k[2][0] * n0 + dp_k[2][1] * n1 + dp_k[2][2] * n2;
    return s;
  endfunction

  always @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < 3; i++)
        for (int p = 0; p < 3; p++) begin
          dp_k[i][p] <= 0;
          dp_w[i][p] <= 0;
        end
      dp_ki <= 0; dp_s1 <= 0; dp_s2 <= 0;
    end else begin
      dp_s2 <= dp_s1;
      if (o_conv_valid && !o_conv_selecK_I) begin
        dp_k[dp_ki][0] <= int'(o_conv_data0);
        dp_k[dp_ki][1] <= int'(o_conv_data1);
        dp_k[dp_ki][2] <= int'(o_conv_data2);
        dp_ki <= (dp_ki == 2) ? 0 : dp_ki + 1;
      end
      if (o_conv_valid && o_conv_selecK_I) begin
        dp_w[0] <= dp_w[1];
        dp_w[1] <= dp_w[2];
        dp_w[2][0] <= int'(o_conv_data0);
        dp_w[2][1] <= int'(o_conv_data1);
        dp_w[2][2] <= int'(o_conv_data2);
        dp_s1 <= dp_sum(int'(o_conv_data0), int'(o_conv_data1), int'(o_conv_data2));
      end
    end
  end
  assign i_conv_result = CONV_LEN'(dp_s2);

  // ---------------- result consumer ----------------
  always @(posedge clk) begin
    #2;
    if (stall_cnt > 0 && o_result_valid) begin
      i_result_ready = 1'b0;
      stall_cnt--;
    end else begin
      i_result_ready = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int hs_cyc = 0, img_pre = 0;
  bit first_seen = 0, rv_prev = 0, prev_hold = 0, prev_last = 0;
  int prev_res = 0;

  always @(negedge clk) begin
    if (i_reset) begin
      first_seen = 0; img_pre = 0; rv_prev = 0; prev_hold = 0;
    end else begin
      chk("conv_valid_is_handshake", o_conv_valid, i_row_valid & o_row_ready);
      if (o_conv_valid) begin
        if (o_conv_selecK_I) begin
          hs_cyc = cyc;
          if (!first_seen) img_pre++;
        end else begin
          k_hs_total++;
        end
      end
      if (o_result_valid) begin
        chk("row_ready_low_in_out", o_row_ready, 0);
        if (!rv_prev) chk("result_latency", cyc, hs_cyc + 3);
        if (!first_seen) begin
          chk("priming_rows", img_pre, M_LEN);
          first_seen = 1;
        end
      end
      if (prev_hold) begin
        chk("hold_valid", o_result_valid, 1);
        chk("hold_result", o_result, prev_res);
        chk("hold_last", o_result_last, prev_last);
      end
      if (o_result_valid && i_result_ready) begin
        if (exp_val.size() == 0) begin
          chk("unexpected_result", o_result, -1);
        end else begin
          chk("result", o_result, exp_val.pop_front());
          chk("result_last", o_result_last, exp_last.pop_front());
        end
        got_q.push_back(int'(o_result));
        res_total++;
      end else if (!o_result_valid) begin
        chk("last_without_valid", o_result_last, 0);
      end
      prev_hold = o_result_valid && !i_result_ready;
      prev_res  = int'(o_result);
      prev_last = o_result_last;
      rv_prev   = o_result_valid;
      if (o_done) done_cnt++;
      if (!o_busy) begin first_seen = 0; img_pre = 0; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [23:0] mk_row(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic send_row(input logic [23:0] d);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    i_row_valid = 1'b1;
    i_row_data  = d;
    while (!o_row_ready && t < 300) begin tick(); t++; end
    if (t >= 300) chk("row_handshake_timeout", t, 0);
    tick();
    i_row_valid = 1'b0;
  endtask

  task automatic push_expected();
    for (int j = 0; j < NRES; j++) begin
      int s = 0;
      for (int i = 0; i < M_LEN; i++)
        for (int p = 0; p < 3; p++) s += kern_m[i][p] * img_m[j + i][p];
      exp_val.push_back(s);
      exp_last.push_back(j == NRES - 1);
    end
  endtask

  task automatic run_frame(input bit keep);
    int d0 = done_cnt, r0 = res_total, k0 = k_hs_total, t = 0;
    if (!keep)
      for (int i = 0; i < 3; i++)
        for (int p = 0; p < 3; p++) kern_m[i][p] = 1;
    push_expected();
    got_q.delete();
    i_start = 1'b1; i_keep_kernel = keep;
    tick();
    i_start = 1'b0; i_keep_kernel = 1'b0;
    if (!keep) repeat (M_LEN) send_row(mk_row(1, 1, 1));
    for (int r = 0; r < IMG_ROWS; r++) begin
      if (r == 4) i_start = 1'b1;   // must be ignored while busy
      send_row(mk_row(img_m[r][0], img_m[r][1], img_m[r][2]));
      i_start = 1'b0;
    end
    while (done_cnt == d0 && t < 300) begin tick(); t++; end
    repeat (3) tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("results_per_frame", res_total - r0, NRES);
    chk("expected_left", exp_val.size(), 0);
    chk("kernel_loads", k_hs_total - k0, keep ? 0 : M_LEN);
    chk("idle_after_frame", o_busy, 0);
    $display("[TB] frame keep=%0d gaps=%0d: %0d results, done=%0d",
             keep, gaps, res_total - r0, done_cnt - d0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_row_ready"}, o_row_ready, 0);
    chk({tag, "_conv_valid"}, o_conv_valid, 0);
    chk({tag, "_result_valid"}, o_result_valid, 0);
    chk({tag, "_result_last"}, o_result_last, 0);
    chk({tag, "_result"}, o_result, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  task automatic set_image(input int mode);
    for (int r = 0; r < IMG_ROWS; r++)
      for (int p = 0; p < 3; p++) img_m[r][p] = (mode == 0) ? r + 1 : mode;
  endtask

  initial begin
    int lit_ramp [NRES] = '{18, 27, 36, 45, 54, 63};
    int d0;
    i_reset = 1'b1; i_start = 1'b0; i_keep_kernel = 1'b0;
    i_row_valid = 1'b0; i_row_data = '0;
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 3; p++) kern_m[i][p] = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    i_reset = 1'b0;
    tick();

    // Kernel reuse straight after reset uses the cleared kernel.
    set_image(0);
    run_frame(1'b1);
    foreach (got_q[i]) chk("zero_kernel_result", got_q[i], 0);

    // Ramp frame with a 10-cycle hold on the first result.
    set_image(0);
    stall_cnt = 10;
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 3; p++) kern_m[i][p] = 1;
    push_expected();
    for (int j = 0; j < NRES; j++) chk("model_ramp", exp_val[j], lit_ramp[j]);
    exp_val.delete(); exp_last.delete();
    run_frame(1'b0);
    chk("ramp_count", got_q.size(), NRES);
    foreach (got_q[i]) if (i < NRES) chk("ramp_literal", got_q[i], lit_ramp[i]);

    // Same frame with random gaps in row valid.
    gaps = 1;
    run_frame(1'b0);
    foreach (got_q[i]) if (i < NRES) chk("gap_literal", got_q[i], lit_ramp[i]);
    gaps = 0;

    // Kernel kept, image rows all 2.
    set_image(2);
    run_frame(1'b1);
    foreach (got_q[i]) chk("keep_literal", got_q[i], 18);

    // Reset while WAIT2 is holding the frame's first result.
    d0 = done_cnt;
    i_start = 1'b1; i_keep_kernel = 1'b1;
    tick();
    i_start = 1'b0; i_keep_kernel = 1'b0;
    repeat (M_LEN) send_row(mk_row(1, 1, 1));   // now in WAIT1
    tick();                                     // now in WAIT2
    i_reset = 1'b1;
    tick();
    check_idle_outputs("midframe_reset");
    i_reset = 1'b0;
    exp_val.delete(); exp_last.delete();
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 3; p++) kern_m[i][p] = 0;
    repeat (4) tick();
    chk("no_done_after_reset", done_cnt - d0, 0);
    $display("[TB] mid-frame reset: busy=%0d done pulses=%0d", o_busy, done_cnt - d0);

    // A clean frame after the reset.
    set_image(0);
    run_frame(1'b0);
    foreach (got_q[i]) if (i < NRES) chk("post_reset_literal", got_q[i], lit_ramp[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
